// File: rtl/sdram_fifo_ctrl.sv
// sdram_fifo_ctrl: write/read FIFOs feeding sdram_ctrl, with burst request
// generation and circular burst addressing for each direction.
module sdram_fifo_ctrl #(
  parameter int FIFO_AW = 10
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               wr_fifo_wr_en,
  input  logic [15:0]        wr_fifo_wr_data,
  input  logic [23:0]        wr_b_addr,
  input  logic [23:0]        wr_e_addr,
  input  logic [9:0]         wr_burst_len,
  input  logic               wr_rst,
  output logic [FIFO_AW:0]   wr_fifo_num,
  output logic               wr_ovf,
  input  logic               rd_fifo_rd_en,
  output logic [15:0]        rd_fifo_rd_data,
  input  logic [23:0]        rd_b_addr,
  input  logic [23:0]        rd_e_addr,
  input  logic [9:0]         rd_burst_len,
  input  logic               rd_rst,
  input  logic               read_valid,
  output logic [FIFO_AW:0]   rd_fifo_num,
  input  logic               init_end,
  output logic               sdram_wr_req,
  input  logic               sdram_wr_ack,
  output logic [23:0]        sdram_wr_addr,
  output logic [15:0]        sdram_data_in,
  output logic               sdram_rd_req,
  input  logic               sdram_rd_ack,
  output logic [23:0]        sdram_rd_addr,
  input  logic [15:0]        sdram_data_out
);
  localparam int DEPTH = 1 << FIFO_AW;
  typedef enum logic [2:0] {IDLE, WR_WAIT, WR_BURST, RD_WAIT, RD_BURST} state_t;
  state_t state;
  logic [15:0] wmem [DEPTH];
  logic [15:0] rmem [DEPTH];
  logic [FIFO_AW-1:0] wwp, wrp, rwp, rrp;
  logic wr_busy, rd_busy, wr_full, rd_full, wr_empty, rd_empty;
  logic wr_push, wr_pop, rd_push, rd_pop;
  logic wr_pend, rd_pend, wr_clr, rd_clr, any_clr;
  logic wr_started, rd_started, wr_ack_d, rd_ack_d, wc, rc;

  function automatic logic [23:0] step(input logic [23:0] a, input logic [23:0] b,
                                       input logic [23:0] e, input logic [9:0] l);
    logic [23:0] n;
    n = a + {14'b0, l};
    return ({1'b0, n} + {15'b0, l} > {1'b0, e}) ? b : n;
  endfunction

  assign wr_busy  = (state == WR_WAIT) || (state == WR_BURST);
  assign rd_busy  = (state == RD_WAIT) || (state == RD_BURST);
  assign wr_full  = wr_fifo_num[FIFO_AW];
  assign rd_full  = rd_fifo_num[FIFO_AW];
  assign wr_empty = wr_fifo_num == '0;
  assign rd_empty = rd_fifo_num == '0;
  assign wr_push  = wr_fifo_wr_en & ~wr_full;
  assign wr_pop   = sdram_wr_ack & wr_busy & ~wr_empty;
  assign rd_push  = sdram_rd_ack & rd_busy & ~rd_full;
  assign rd_pop   = rd_fifo_rd_en & ~rd_empty;
  // A clear requested during the path's own burst waits until the FSM is back in IDLE
  assign wr_clr   = (wr_rst | wr_pend) & ~wr_busy;
  assign rd_clr   = (rd_rst | rd_pend) & ~rd_busy;
  assign any_clr  = wr_clr | rd_clr;
  assign wc = init_end & (wr_burst_len != '0) & (int'(wr_fifo_num) >= int'(wr_burst_len));
  assign rc = init_end & read_valid & (rd_burst_len != '0) &
              ((DEPTH - int'(rd_fifo_num)) >= int'(rd_burst_len));
  assign sdram_data_in = wr_empty ? 16'h0 : wmem[wrp];

  always_ff @(posedge sys_clk)
    if (wr_push) wmem[wwp] <= wr_fifo_wr_data;

  always_ff @(posedge sys_clk)
    if (rd_push) rmem[rwp] <= sdram_data_out;

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      wwp <= '0;
      wrp <= '0;
      wr_fifo_num <= '0;
      wr_ovf <= 1'b0;
    end else if (wr_clr) begin
      wwp <= '0;
      wrp <= '0;
      wr_fifo_num <= '0;
      wr_ovf <= 1'b0;
    end else begin
      if (wr_push) wwp <= wwp + FIFO_AW'(1);
      if (wr_pop) wrp <= wrp + FIFO_AW'(1);
      wr_fifo_num <= wr_fifo_num + {{FIFO_AW{1'b0}}, wr_push} - {{FIFO_AW{1'b0}}, wr_pop};
      if (wr_fifo_wr_en & wr_full) wr_ovf <= 1'b1;
    end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      rwp <= '0;
      rrp <= '0;
      rd_fifo_num <= '0;
      rd_fifo_rd_data <= '0;
    end else if (rd_clr) begin
      rwp <= '0;
      rrp <= '0;
      rd_fifo_num <= '0;
    end else begin
      if (rd_push) rwp <= rwp + FIFO_AW'(1);
      if (rd_pop) begin
        rrp <= rrp + FIFO_AW'(1);
        rd_fifo_rd_data <= rmem[rrp];
      end
      rd_fifo_num <= rd_fifo_num + {{FIFO_AW{1'b0}}, rd_push} - {{FIFO_AW{1'b0}}, rd_pop};
    end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      sdram_wr_req <= 1'b0;
      sdram_rd_req <= 1'b0;
      sdram_wr_addr <= '0;
      sdram_rd_addr <= '0;
      wr_started <= 1'b0;
      rd_started <= 1'b0;
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
      wr_ack_d <= 1'b0;
      rd_ack_d <= 1'b0;
    end else begin
      wr_ack_d <= sdram_wr_ack;
      rd_ack_d <= sdram_rd_ack;
      wr_pend <= (wr_rst & wr_busy) | (wr_pend & ~wr_clr);
      rd_pend <= (rd_rst & rd_busy) | (rd_pend & ~rd_clr);
      case (state)
        IDLE: begin
          if (!wr_started) sdram_wr_addr <= wr_b_addr;
          if (!rd_started) sdram_rd_addr <= rd_b_addr;
          if (wc & ~any_clr) begin
            state <= WR_WAIT;
            sdram_wr_req <= 1'b1;
            wr_started <= 1'b1;
          end else if (rc & ~any_clr) begin
            state <= RD_WAIT;
            sdram_rd_req <= 1'b1;
            rd_started <= 1'b1;
          end
        end
        WR_WAIT: if (sdram_wr_ack) begin
          sdram_wr_req <= 1'b0;
          state <= WR_BURST;
        end
        WR_BURST: if (wr_ack_d & ~sdram_wr_ack) begin
          sdram_wr_addr <= step(sdram_wr_addr, wr_b_addr, wr_e_addr, wr_burst_len);
          state <= IDLE;
        end
        RD_WAIT: if (sdram_rd_ack) begin
          sdram_rd_req <= 1'b0;
          state <= RD_BURST;
        end
        RD_BURST: if (rd_ack_d & ~sdram_rd_ack) begin
          sdram_rd_addr <= step(sdram_rd_addr, rd_b_addr, rd_e_addr, rd_burst_len);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (wr_clr) begin
        sdram_wr_addr <= wr_b_addr;
        wr_started <= 1'b0;
      end
      if (rd_clr) begin
        sdram_rd_addr <= rd_b_addr;
        rd_started <= 1'b0;
      end
    end
endmodule
